// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Framed serial-in/parallel-out capture controller. A one-cycle start strobe
// opens a frame; exactly WIDTH qualified serial bits (bit_valid=1) are shifted
// into an internal register. The finished word is then presented on a
// valid/ready handshake and held until it is consumed.
//
// Handshake: word_out is valid and frozen while word_valid=1. A transfer
// happens on the rising edge where word_valid && word_ready are both 1;
// word_valid drops on that same edge unless a new frame completes later.
// word_valid never depends combinationally on word_ready.
//
// Optional feature (macro SIPO_FRAME_CTRL_PARITY_EN):
//   After WIDTH data bits, one extra qualified bit is taken as an even-parity
//   bit; parity_err = (^data) ^ parity_bit is presented with word_valid and
//   cleared when the word is consumed. Without the macro the parity state and
//   the parity_err port do not exist.
//
// Parameters:
//   WIDTH      data bits per frame (2..32)
//   MSB_FIRST  1: first received bit ends in word_out[WIDTH-1]
//              0: first received bit ends in word_out[0]
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       one-cycle frame-start strobe
//   bit_valid   serial_in is sampled when 1
//   serial_in   serial data bit
//   word_out    assembled word (stable while word_valid=1)
//   word_valid  word_out holds a complete frame
//   word_ready  consumer accepts the word when word_valid=1
//   busy        high while a frame is being shifted in
//   overrun     sticky: a bit or start arrived while a word was held
//   parity_err  parity mismatch of the held word (macro only)
//   state_dbg   current FSM state (0 idle, 1 shift, 2 parity, 3 hold)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  output logic             parity_err,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  // Shift register value after accepting serial_in this cycle.
  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], serial_in};
    else           sr_next = {serial_in, sr[WIDTH-1:1]};
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sr         <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // bit_valid is ignored until a frame is opened.
          if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            sr    <= '0;
            busy  <= 1'b1;
          end
        end

        S_SHIFT: begin
          // A restart wins over any bit presented in the same cycle,
          // including the last bit of the frame.
          if (start) begin
            cnt <= '0;
            sr  <= '0;
          end else if (bit_valid) begin
            sr <= sr_next;
            if (cnt == LAST) begin
              word_out <= sr_next;
              cnt      <= '0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
              state    <= S_PARITY;
`else
              state      <= S_HOLD;
              word_valid <= 1'b1;
              busy       <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

`ifdef SIPO_FRAME_CTRL_PARITY_EN
        S_PARITY: begin
          if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            sr    <= '0;
          end else if (bit_valid) begin
            // Even parity: data bits plus parity bit must xor to 0.
            parity_err <= (^word_out) ^ serial_in;
            word_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= S_HOLD;
          end
        end
`endif

        S_HOLD: begin
          // Any bit arriving while a word is held is lost; a start is lost
          // only if it cannot chain onto the handover.
          if (bit_valid || (start && !word_ready)) begin
            overrun <= 1'b1;
          end
          if (word_ready) begin
            word_valid <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (start) begin
              // Back-to-back frame: no idle cycle between words.
              state <= S_SHIFT;
              cnt   <= '0;
              sr    <= '0;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_ctrl
//
// Two instances (MSB-first and LSB-first, WIDTH=4) receive identical stimulus.
// A behavioural model keeps the received bits of the current frame in a queue
// and packs the word arithmetically when the frame is complete. After every
// clock edge all outputs of both instances are compared against the model;
// consumed words are also checked against an expected-word queue. Directed
// sequences add literal expectations, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, bit_valid, serial_in, word_ready;

  logic [W-1:0] word_m, word_l;
  logic         valid_m, valid_l, busy_m, busy_l, over_m, over_l;
  logic [1:0]   st_m, st_l;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  logic         perr_m, perr_l;
`endif

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .serial_in(serial_in), .word_out(word_m), .word_valid(valid_m),
    .word_ready(word_ready), .busy(busy_m), .overrun(over_m),
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    .parity_err(perr_m),
`endif
    .state_dbg(st_m)
  );

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .serial_in(serial_in), .word_out(word_l), .word_valid(valid_l),
    .word_ready(word_ready), .busy(busy_l), .overrun(over_l),
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    .parity_err(perr_l),
`endif
    .state_dbg(st_l)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];        // words completed, awaiting consumption (MSB-first)
  bit           bits[$];         // bits received in the current frame
  bit           m_in_frame, m_want_parity;
  logic [W-1:0] m_word_m, m_word_l;
  logic         m_valid, m_busy, m_over, m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First received bit goes to the top (msb=1) or bottom (msb=0) of the word.
  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < bits.size(); i++) begin
      if (bits[i]) begin
        if (msb) w = w | (W'(1) << (W - 1 - i));
        else     w = w | (W'(1) << i);
      end
    end
    return w;
  endfunction

  function automatic bit bits_xor();
    bit x;
    x = 1'b0;
    foreach (bits[i]) x = x ^ bits[i];
    return x;
  endfunction

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // Advance the model to the values the outputs must hold after this edge.
  task automatic model_edge(input logic st, bv, si, rdy, rs);
    if (rs) begin
      bits.delete(); exp_q.delete();
      m_in_frame = 0; m_want_parity = 0;
      m_word_m = '0; m_word_l = '0;
      m_valid = 0; m_busy = 0; m_over = 0; m_perr = 0;
    end else if (m_valid) begin
      if (bv || (st && !rdy)) m_over = 1;
      if (rdy) begin
        m_valid = 0; m_perr = 0;
        if (st) begin
          m_in_frame = 1; m_busy = 1; bits.delete();
        end
      end
    end else if (m_in_frame) begin
      if (st) begin
        bits.delete(); m_want_parity = 0;
      end else if (bv) begin
        if (m_want_parity) begin
          m_perr = bits_xor() ^ si;
          m_want_parity = 0; m_in_frame = 0;
          m_valid = 1; m_busy = 0;
          exp_q.push_back(m_word_m);
        end else begin
          bits.push_back(si);
          if (bits.size() == W) begin
            m_word_m = pack(1'b1);
            m_word_l = pack(1'b0);
            if (PAR) m_want_parity = 1;
            else begin
              m_in_frame = 0; m_valid = 1; m_busy = 0;
              exp_q.push_back(m_word_m);
            end
          end
        end
      end
    end else if (st) begin
      m_in_frame = 1; m_busy = 1; bits.delete();
    end
  endtask

  // ---------------- driver + compare ----------------
  // Called at a falling edge: drives inputs, checks a handover against the
  // expected-word queue, advances the model, then compares after the edge.
  task automatic step(input logic st, bv, si, rdy, rs);
    logic [W-1:0] e;
    start = st; bit_valid = bv; serial_in = si; word_ready = rdy; rst = rs;
    if (!rs && m_valid && rdy) begin
      if (exp_q.size() == 0) chk("handover_queue_empty", 32'd0, 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("handover_word", 32'(word_m), 32'(e));
      end
    end
    model_edge(st, bv, si, rdy, rs);
    @(negedge clk);
    chk("word_msb",   32'(word_m),  32'(m_word_m));
    chk("word_lsb",   32'(word_l),  32'(m_word_l));
    chk("valid_msb",  32'(valid_m), 32'(m_valid));
    chk("valid_lsb",  32'(valid_l), 32'(m_valid));
    chk("busy_msb",   32'(busy_m),  32'(m_busy));
    chk("busy_lsb",   32'(busy_l),  32'(m_busy));
    chk("overrun_msb", 32'(over_m), 32'(m_over));
    chk("overrun_lsb", 32'(over_l), 32'(m_over));
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    chk("perr_msb", 32'(perr_m), 32'(m_perr));
    chk("perr_lsb", 32'(perr_l), 32'(m_perr));
`endif
  endtask

  task automatic send_bits(input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, b[i], 1'b0, 1'b0);
  endtask

  // Parity bit is sent only in the parity build.
  task automatic send_frame(input logic [W-1:0] b, input logic p);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(b);
    if (PAR) step(1'b0, 1'b1, p, 1'b0, 1'b0);
  endtask

  initial begin
    start = 0; bit_valid = 0; serial_in = 0; word_ready = 0; rst = 1;
    model_edge(0, 0, 0, 0, 1);

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_word", 32'(word_m), 32'd0);
    chk("reset_valid", 32'(valid_m), 32'd0);

    // MSB/LSB-first capture of 1,0,1,1 (parity bit 1 makes it even)
    send_frame(4'b1011, 1'b1);
    chk("msb_word_lit", 32'(word_m), 32'hB);
    chk("lsb_word_lit", 32'(word_l), 32'hD);
    chk("valid_lit", 32'(valid_m), 32'd1);
    chk("busy_lit", 32'(busy_m), 32'd0);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    chk("perr_ok_lit", 32'(perr_m), 32'd0);
`endif

    // Backpressure with bits arriving -> overrun, word frozen
    for (int i = 0; i < 5; i++) step(0, 1, 1'($urandom_range(0, 1)), 0, 0);
    chk("overrun_lit", 32'(over_m), 32'd1);
    chk("frozen_word_lit", 32'(word_m), 32'hB);
    step(0, 0, 0, 1, 0);
    chk("drop_valid_lit", 32'(valid_m), 32'd0);
    chk("overrun_sticky_lit", 32'(over_m), 32'd1);

    // Mid-frame restart
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    send_frame(4'b0010, 1'b0);
    chk("restart_word_lit", 32'(word_m), 32'h2);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    chk("perr_bad_lit", 32'(perr_m), 32'd1);
`endif

    // Back-to-back: start together with word_ready in hold
    step(1, 0, 0, 1, 0);
    chk("b2b_busy_lit", 32'(busy_m), 32'd1);
    chk("b2b_valid_lit", 32'(valid_m), 32'd0);
    send_bits(4'b0110);
    if (PAR) step(0, 1, 0, 0, 0);
    chk("b2b_word_lit", 32'(word_m), 32'h6);
    step(0, 0, 0, 1, 0);

    // Reset after two bits, then ten quiet cycles without a word
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_mid_busy_lit", 32'(busy_m), 32'd0);
    chk("rst_mid_over_lit", 32'(over_m), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    chk("no_word_after_rst_lit", 32'(valid_m), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
